reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Generates the active-high power_on_reset that drives the f8 system, and sits directly upstream of it.
- Stretches the board reset to a fixed hold time.
- Restarts the system after a trap or a watchdog timeout.
- Latches into a halted state after too many traps, so the bench or board can inspect the failure.

Parameters:
HOLD_CYCLES, 16, cycles system_reset stays high after each (re)start; must be >= 2
WDT_CYCLES, 4096, watchdog timeout in cycles; must be >= 2
MAX_TRAPS, 3, trap restarts before halting; 0 = never halt
CNT_W, 16, width of hold/watchdog counters; must satisfy 2^CNT_W > max(HOLD_CYCLES, WDT_CYCLES)

Ports:
clk  input  1  system clock
power_on_reset_n  input  1  synchronous, active-low reset
trap  input  1  trap flag from system, sampled on posedge clk
wdt_enable  input  1  watchdog enable (level)
wdt_kick  input  1  watchdog kick, e.g. a gpio pin; a rising edge restarts the timeout
power_on_reset  output  1  active-high reset into system
halted  output  1  high while in HALTED
reset_cause  output  2  0=POR, 1=trap, 2=watchdog, 3=reserved
trap_count  output  8  traps seen since POR, saturating at 255
wdt_expired  output  1  one-cycle pulse on watchdog timeout

Behaviour:
- All logic is on posedge clk. Reset is synchronous and active-low: power_on_reset_n=0 at an edge forces the reset values below.
- Reset values:
  - state=HOLD, hold_cnt=0, wdt_cnt=0, kick_q=0
  - power_on_reset=1, halted=0, reset_cause=0, trap_count=0, wdt_expired=0
- All outputs are registered.
- HOLD:
  - power_on_reset=1; hold_cnt increments every cycle.
  - When hold_cnt==HOLD_CYCLES-1: go to RUN and clear hold_cnt.
  - Result: power_on_reset falls exactly HOLD_CYCLES edges after the first edge with power_on_reset_n=1.
  - trap and the watchdog are ignored; wdt_cnt is held at 0.
- RUN:
  - power_on_reset=0.
  - Trap: if trap=1 at an edge:
    - trap_count <= sat(trap_count+1); reset_cause <= 1.
    - If MAX_TRAPS!=0 and the new count >= MAX_TRAPS: go to HALTED. Otherwise go to HOLD.
    - power_on_reset is 1 on the following cycle.
  - Watchdog: with wdt_enable=1, wdt_cnt increments each cycle.
    - A kick edge (wdt_kick & ~kick_q) clears wdt_cnt to 0 that cycle.
    - When wdt_cnt==WDT_CYCLES-1 with no kick that cycle:
      - wdt_expired=1 for one cycle; reset_cause <= 2; go to HOLD.
      - trap_count is unchanged.
  - wdt_enable=0 holds wdt_cnt at 0.
  - Simultaneous trap and timeout in the same cycle: the trap wins. No wdt_expired pulse; cause=1.
  - A kick in the expiry cycle wins over the timeout.
- HALTED:
  - power_on_reset=1, halted=1.
  - Stays until power_on_reset_n=0. trap and kick are ignored.
- kick_q samples wdt_kick every cycle in all states, so the first kick after a restart is edge-correct.
- reset_cause and trap_count persist across trap/watchdog restarts. Only POR clears them.
- A POR in any state, including mid-HOLD or in HALTED, restarts the full HOLD_CYCLES count.

Decomposition:
- Shared package f8_reset_pkg contains:
  - typedef enum logic [1:0] state_t {HOLD, RUN, HALTED}
  - typedef enum logic [1:0] cause_t {CAUSE_POR, CAUSE_TRAP, CAUSE_WDT}
  - localparam TRAP_CNT_W = 8
- One sub-module, wdt_timer:
  - Inputs: clk, power_on_reset_n, enable, clear, kick.
  - Outputs: expire pulse.
  - Parameterised by WDT_CYCLES and CNT_W.
  - The sequencer drives enable = (state==RUN) & wdt_enable, and clear = (state!=RUN).

Test Plan:
- POR: hold power_on_reset_n=0 for 5 edges, then release. power_on_reset stays 1 for exactly 16 edges, then 0; halted=0, reset_cause=0, trap_count=0.
- Single trap: in RUN, pulse trap for 1 cycle. Next cycle power_on_reset=1 for 16 cycles, then 0; trap_count=1, reset_cause=1.
- Trap halt: three traps in successive RUN phases (MAX_TRAPS=3). After the third: halted=1, power_on_reset=1 permanently, trap_count=3. A further trap leaves trap_count=3. A POR then clears all.
- Watchdog, with WDT_CYCLES=64 and wdt_enable=1:
  - No kick: wdt_expired pulses on RUN cycle 64; reset_cause=2; trap_count unchanged; re-HOLD for 16 cycles.
  - Kick every 50 cycles: no expiry over 1000 cycles.
- Simultaneous events: trap asserted in the same cycle as watchdog expiry. No wdt_expired pulse; reset_cause=1; trap_count increments.
- Reset mid-operation: power_on_reset_n=0 at HOLD cycle 8, released 2 cycles later. The full 16-cycle hold restarts and the counters clear.

Source files
------------

// File: rtl/f8_reset_pkg.sv
// Shared types for the f8 reset sequencer.
//   state_t    : sequencer phase (HOLD, RUN, HALTED)
//   cause_t    : encoding of the reset_cause output
//   TRAP_CNT_W : width of the saturating trap counter
//   sat_inc    : saturating increment for the trap counter
package f8_reset_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_TRAP = 2'd1,
    CAUSE_WDT  = 2'd2
  } cause_t;

  localparam int TRAP_CNT_W = 8;

  function automatic logic [TRAP_CNT_W-1:0] sat_inc(input logic [TRAP_CNT_W-1:0] v);
    return (&v) ? v : v + TRAP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/reset_sequencer_wdt_timer.sv
// Watchdog timer for the reset sequencer.
// Ports:
//   clk              : system clock
//   power_on_reset_n : synchronous active-low reset
//   enable           : count while high; low holds the counter at 0
//   clear            : forces the counter to 0 (sequencer not in RUN)
//   kick             : level input; a rising edge restarts the timeout
//   expire           : combinational, high on the edge where the timeout is reached
module wdt_timer #(
  parameter int WDT_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic power_on_reset_n,
  input  logic enable,
  input  logic clear,
  input  logic kick,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kick_q;
  logic             kick_rise;
  logic             at_limit;

  assign kick_rise = kick & ~kick_q;
  assign at_limit  = (cnt_q == CNT_W'(WDT_CYCLES - 1));

  // A kick edge in the same cycle as the limit wins over the timeout.
  assign expire = enable & ~clear & ~kick_rise & at_limit;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || !enable || kick_rise || at_limit) begin
      cnt_d = '0;
    end
  end

  // kick_q samples in every state so the first kick after a restart is seen as an edge.
  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      cnt_q  <= '0;
      kick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      kick_q <= kick;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer for the f8 system: stretches the board reset, restarts the
// system after a trap or watchdog timeout, and halts after too many traps.
// Ports:
//   clk              : system clock
//   power_on_reset_n : synchronous active-low board reset
//   trap             : trap flag from the system
//   wdt_enable       : watchdog enable (level)
//   wdt_kick         : watchdog kick, rising edge restarts the timeout
//   power_on_reset   : active-high reset into the system (registered)
//   halted           : high while halted after too many traps (registered)
//   reset_cause      : 0=POR, 1=trap, 2=watchdog (registered)
//   trap_count       : traps since POR, saturating at 255 (registered)
//   wdt_expired      : one-cycle pulse on watchdog timeout (registered)
//   dbg_state_o      : current sequencer phase, for observation
module reset_sequencer
  import f8_reset_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int WDT_CYCLES  = 4096,
  parameter int MAX_TRAPS   = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  power_on_reset_n,
  input  logic                  trap,
  input  logic                  wdt_enable,
  input  logic                  wdt_kick,
  output logic                  power_on_reset,
  output logic                  halted,
  output logic [1:0]            reset_cause,
  output logic [TRAP_CNT_W-1:0] trap_count,
  output logic                  wdt_expired,
  output state_t                dbg_state_o
);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [TRAP_CNT_W-1:0]   trap_cnt_q, trap_cnt_d;
  cause_t                  cause_q, cause_d;
  logic                    wdt_exp_q, wdt_exp_d;
  logic                    por_q, halted_q;
  logic                    wdt_fire;

  wdt_timer #(
    .WDT_CYCLES (WDT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_wdt (
    .clk              (clk),
    .power_on_reset_n (power_on_reset_n),
    .enable           ((state_q == RUN) & wdt_enable),
    .clear            (state_q != RUN),
    .kick             (wdt_kick),
    .expire           (wdt_fire)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    trap_cnt_d = trap_cnt_q;
    cause_d    = cause_q;
    wdt_exp_d  = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        // A trap takes priority over a simultaneous watchdog timeout.
        if (trap) begin
          trap_cnt_d = sat_inc(trap_cnt_q);
          cause_d    = CAUSE_TRAP;
          if (MAX_TRAPS != 0 && int'(trap_cnt_d) >= MAX_TRAPS) begin
            state_d = HALTED;
          end else begin
            state_d = HOLD;
          end
        end else if (wdt_fire) begin
          wdt_exp_d = 1'b1;
          cause_d   = CAUSE_WDT;
          state_d   = HOLD;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      trap_cnt_q <= '0;
      cause_q    <= CAUSE_POR;
      wdt_exp_q  <= 1'b0;
      por_q      <= 1'b1;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      trap_cnt_q <= trap_cnt_d;
      cause_q    <= cause_d;
      wdt_exp_q  <= wdt_exp_d;
      por_q      <= (state_d != RUN);
      halted_q   <= (state_d == HALTED);
    end
  end

  assign power_on_reset = por_q;
  assign halted         = halted_q;
  assign reset_cause    = cause_q;
  assign trap_count     = trap_cnt_q;
  assign wdt_expired    = wdt_exp_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural model.
module tb_reset_sequencer;
  import f8_reset_pkg::*;

  localparam int P_HOLD = 16;
  localparam int P_WDT  = 64;
  localparam int P_MAXT = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, trap, en, kick;
  logic       por, halted, wexp;
  logic [1:0] cause;
  logic [7:0] tcnt;
  state_t     dbg;

  reset_sequencer #(
    .HOLD_CYCLES (P_HOLD),
    .WDT_CYCLES  (P_WDT),
    .MAX_TRAPS   (P_MAXT),
    .CNT_W       (16)
  ) dut (
    .clk              (clk),
    .power_on_reset_n (rst_n),
    .trap             (trap),
    .wdt_enable       (en),
    .wdt_kick         (kick),
    .power_on_reset   (por),
    .halted           (halted),
    .reset_cause      (cause),
    .trap_count       (tcnt),
    .wdt_expired      (wexp),
    .dbg_state_o      (dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: phase, cycles left in hold, enabled cycles since the
  // watchdog last restarted, and the sticky cause/count
  state_t m_phase = HOLD;
  int     m_hold_left = 0;
  int     m_idle = 0;
  int     m_cnt = 0;
  int     m_cause = 0;
  bit     m_exp = 0;
  bit     m_prev_kick = 0;
  bit     m_valid = 0;

  always @(posedge clk) begin
    bit rise;
    m_exp = 0;
    if (!rst_n) begin
      m_valid     = 1;
      m_phase     = HOLD;
      m_hold_left = P_HOLD;
      m_idle      = 0;
      m_cnt       = 0;
      m_cause     = 0;
      m_prev_kick = 0;
    end else if (m_valid) begin
      rise        = kick && !m_prev_kick;
      m_prev_kick = kick;
      case (m_phase)
        HOLD: begin
          m_hold_left = m_hold_left - 1;
          if (m_hold_left == 0) begin
            m_phase = RUN;
            m_idle  = 0;
          end
        end
        RUN: begin
          if (trap) begin
            m_cnt       = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_cause     = 1;
            m_phase     = (P_MAXT != 0 && m_cnt >= P_MAXT) ? HALTED : HOLD;
            m_hold_left = P_HOLD;
          end else if (!en || rise) begin
            m_idle = 0;
          end else if (m_idle + 1 == P_WDT) begin
            m_exp       = 1;
            m_cause     = 2;
            m_phase     = HOLD;
            m_hold_left = P_HOLD;
          end else begin
            m_idle = m_idle + 1;
          end
        end
        default: ;
      endcase
    end
  end

  // scoreboard: one compare per cycle of all outputs against the model
  always @(negedge clk) begin
    logic [13:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {(m_phase != RUN), (m_phase == HALTED), 2'(m_cause), 8'(m_cnt), m_exp, 1'b0};
      act_v = {por, halted, cause, tcnt, wexp, 1'b0};
      n_checks++;
      if (act_v !== exp_v || dbg !== m_phase) begin
        n_errors++;
        if (n_errors <= 20)
          $display("FAIL cycle_cmp t=%0t por/halt/cause/cnt/exp got %b/%b/%0d/%0d/%b state %0d, want %b/%b/%0d/%0d/%b state %0d",
                   $time, por, halted, cause, tcnt, wexp, dbg,
                   exp_v[13], exp_v[12], exp_v[11:10], exp_v[9:2], exp_v[1], m_phase);
      end
    end
  end

  // driver / literal-check tasks
  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_run(input int budget);
    int i;
    for (i = 0; i < budget && por !== 1'b0; i++) @(negedge clk);
    n_checks++;
    if (por !== 1'b0) begin
      n_errors++;
      $display("FAIL wait_run timeout t=%0t por=%b", $time, por);
    end
  endtask

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL global_timeout t=%0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst_n = 0; trap = 0; en = 0; kick = 0;

    // POR: 5 edges low, then exactly 16 edges of hold
    step(5);
    check_lit("por_in_reset", por, 1);
    check_lit("halted_in_reset", halted, 0);
    rst_n = 1;
    step(15);
    check_lit("hold15_por", por, 1);
    step(1);
    check_lit("hold16_por", por, 0);
    check_lit("run_cause", cause, 0);
    check_lit("run_tcnt", tcnt, 0);

    // three traps; the third halts
    for (int k = 1; k <= 3; k++) begin
      trap = 1; step(1); trap = 0;
      check_lit("trap_por", por, 1);
      check_lit("trap_count", tcnt, k);
      check_lit("trap_cause", cause, 1);
      if (k < 3) begin
        step(15);
        check_lit("trap_hold15_por", por, 1);
        step(1);
        check_lit("trap_hold16_por", por, 0);
      end else begin
        check_lit("trap_halted", halted, 1);
      end
    end
    step(20);
    trap = 1; step(1); trap = 0;
    check_lit("halt_tcnt_sticky", tcnt, 3);
    check_lit("halt_por", por, 1);
    check_lit("halt_halted", halted, 1);
    rst_n = 0; step(1);
    check_lit("por_clr_tcnt", tcnt, 0);
    check_lit("por_clr_cause", cause, 0);
    check_lit("por_clr_halted", halted, 0);
    rst_n = 1;
    wait_run(40);

    // watchdog, no kick: expiry on the 64th enabled RUN edge
    en = 1;
    step(63);
    check_lit("wdt_pre_exp", wexp, 0);
    check_lit("wdt_pre_por", por, 0);
    step(1);
    check_lit("wdt_exp", wexp, 1);
    check_lit("wdt_cause", cause, 2);
    check_lit("wdt_por", por, 1);
    check_lit("wdt_tcnt", tcnt, 0);
    step(1);
    check_lit("wdt_exp_pulse", wexp, 0);
    wait_run(40);

    // kick every 50 cycles: no expiry over 1000 cycles
    for (int i = 0; i < 1000; i++) begin
      kick = (i % 50 == 0);
      step(1);
    end
    kick = 0;
    check_lit("kick_no_reset_por", por, 0);
    check_lit("kick_cause", cause, 2);

    // trap in the expiry cycle wins
    en = 0; step(1); en = 1;
    step(63);
    trap = 1; step(1); trap = 0;
    check_lit("simul_exp", wexp, 0);
    check_lit("simul_cause", cause, 1);
    check_lit("simul_tcnt", tcnt, 1);
    wait_run(40);

    // kick in the expiry cycle wins
    en = 0; step(1); en = 1;
    step(63);
    kick = 1; step(1); kick = 0;
    check_lit("kick_win_exp", wexp, 0);
    check_lit("kick_win_por", por, 0);

    // POR in the middle of HOLD restarts the full hold
    rst_n = 0; step(1); rst_n = 1;
    step(8);
    rst_n = 0; step(2); rst_n = 1;
    check_lit("midhold_tcnt", tcnt, 0);
    check_lit("midhold_cause", cause, 0);
    step(15);
    check_lit("midhold15_por", por, 1);
    step(1);
    check_lit("midhold16_por", por, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      trap  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 79) == 0) kick = ~kick;
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
